// File: rtl/mux4_serializer.sv
// 4-bit parallel-to-serial front end for a 4:1 mux. Takes a word on a valid/ready
// handshake and walks the mux select across all four bits, optionally idling between words.

module mux4 (
  input  logic       d0_i,
  input  logic       d1_i,
  input  logic       d2_i,
  input  logic       d3_i,
  input  logic [1:0] sel_i,
  output logic       z_o
);

  // Plain 4:1 select
  always_comb begin
    z_o = 1'b0;
    case (sel_i)
      2'd0:    z_o = d0_i;
      2'd1:    z_o = d1_i;
      2'd2:    z_o = d2_i;
      2'd3:    z_o = d3_i;
      default: z_o = 1'b0;
    endcase
  end

endmodule

module mux4_serializer #(
  parameter int          LSB_FIRST  = 1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [3:0] in_data_i,
  output logic       ser_out_o,
  output logic       ser_valid_o,
  output logic       ser_last_o,
  output logic [1:0] sel_o,
  output logic       busy_o
);

  localparam int             GW        = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [1:0]     FIRST_IDX = (LSB_FIRST != 0) ? 2'd0 : 2'd3;
  localparam logic [1:0]     LAST_IDX  = (LSB_FIRST != 0) ? 2'd3 : 2'd0;
  localparam logic [GW-1:0]  GAP_LOAD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      data_q, data_d;
  logic [1:0]      sel_q, sel_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic            at_last_s;
  logic            ready_s;
  logic            accept_s;
  logic [1:0]      sel_step_s;

  assign at_last_s  = (sel_q == LAST_IDX);
  // The final bit cycle can take the next word only when no gap is requested
  assign ready_s    = (state_q == ST_IDLE) ||
                      ((state_q == ST_SHIFT) && at_last_s && (GAP_CYCLES == 0));
  assign accept_s   = in_valid_i && ready_s;
  assign sel_step_s = (LSB_FIRST != 0) ? (sel_q + 2'd1) : (sel_q - 2'd1);

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          data_d  = in_data_i;
          sel_d   = FIRST_IDX;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!at_last_s) begin
          sel_d = sel_step_s;
        end else if (GAP_CYCLES == 0) begin
          if (accept_s) begin
            data_d = in_data_i;
            sel_d  = FIRST_IDX;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == {GW{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      data_q  <= 4'd0;
      sel_q   <= FIRST_IDX;
      gap_q   <= {GW{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      gap_q   <= gap_d;
    end
  end

  mux4 u_mux4 (
    .d0_i  (data_q[0]),
    .d1_i  (data_q[1]),
    .d2_i  (data_q[2]),
    .d3_i  (data_q[3]),
    .sel_i (sel_q),
    .z_o   (ser_out_o)
  );

  // Status is decoded from registered state and forced quiet while reset is held
  assign in_ready_o  = ready_s && !rst_i;
  assign ser_valid_o = (state_q == ST_SHIFT) && !rst_i;
  assign ser_last_o  = ser_valid_o && at_last_s;
  assign busy_o      = (state_q != ST_IDLE) && !rst_i;
  assign sel_o       = sel_q;

endmodule

// File: tb/tb_mux4_serializer.sv
// Scoreboarded random/directed bench for mux4_serializer, run on an LSB-first no-gap
// instance and an MSB-first two-cycle-gap instance side by side.

module tb_mux4_serializer;

  logic clk = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input int inst, input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL inst%0d %s: got %0d expected %0d at %0t", inst, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int         LSB   = (g == 0) ? 1 : 0;
    localparam int         GAP   = (g == 0) ? 0 : 2;
    localparam int         FIRST = (LSB != 0) ? 0 : 3;
    localparam logic [3:0] W0    = (g == 0) ? 4'b1011 : 4'b1000;

    logic       rst      = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data  = 4'd0;
    logic       in_ready, ser_out, ser_valid, ser_last, busy;
    logic [1:0] sel;
    int         exp_q[$];
    bit         done = 1'b0;

    mux4_serializer #(.LSB_FIRST(LSB), .GAP_CYCLES(GAP)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .ser_out_o   (ser_out),
      .ser_valid_o (ser_valid),
      .ser_last_o  (ser_last),
      .sel_o       (sel),
      .busy_o      (busy)
    );

    // Reference: a word becomes four (bit, index, last) entries in emission order
    task automatic push_word(input logic [3:0] w);
      for (int k = 0; k < 4; k++) begin
        int idx = (LSB != 0) ? k : 3 - k;
        int b   = w[idx];
        int l   = (k == 3) ? 1 : 0;
        exp_q.push_back(b * 100 + idx * 10 + l);
      end
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic r, output logic acc);
      @(negedge clk);
      rst      = r;
      in_valid = v;
      in_data  = d;
      if (r) exp_q.delete();
      #2;
      acc = v && in_ready;
      if (acc) push_word(d);
    endtask

    task automatic send(input logic [3:0] w);
      logic acc   = 1'b0;
      int   tries = 0;
      while (!acc && tries < 40) begin
        drive(1'b1, w, 1'b0, acc);
        tries++;
      end
      check(g, "accept_within_bound", int'(acc), 1);
    endtask

    task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) drive(1'b0, 4'($urandom), 1'b0, acc);
    endtask

    // Stimulus
    initial begin
      logic acc;
      drive(1'b1, 4'hF, 1'b1, acc);
      drive(1'b1, 4'hF, 1'b1, acc);
      send(W0);
      idle(6);
      send(4'hA);
      send(4'h5);
      idle(8);
      send(4'hC);
      drive(1'b0, 4'($urandom), 1'b0, acc);
      drive(1'b0, 4'($urandom), 1'b1, acc);
      send(4'h6);
      idle(8);
      for (int i = 0; i < 200; i++) begin
        drive(1'($urandom_range(0, 1)), 4'($urandom),
              ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, acc);
      end
      idle(10);
      done = 1'b1;
    end

    // Monitor: pops the scoreboard on every valid bit and tracks the idle gap
    initial begin
      int e;
      int gap_left      = 0;
      bit ready_pending = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        if (rst) begin
          check(g, "rst_in_ready", int'(in_ready), 0);
          check(g, "rst_ser_valid", int'(ser_valid), 0);
          check(g, "rst_busy", int'(busy), 0);
          check(g, "rst_sel", int'(sel), FIRST);
          gap_left      = 0;
          ready_pending = 1'b0;
        end else begin
          if (gap_left > 0) begin
            check(g, "gap_valid_ready", int'({ser_valid, in_ready}), 0);
            gap_left--;
            if (gap_left == 0) ready_pending = 1'b1;
          end else if (ready_pending) begin
            check(g, "gap_release_ready", int'(in_ready), 1);
            ready_pending = 1'b0;
          end
          if (ser_valid) begin
            if (exp_q.size() == 0) begin
              check(g, "unexpected_valid", int'(ser_valid), 0);
            end else begin
              e = exp_q.pop_front();
              check(g, "ser_out", int'(ser_out), e / 100);
              check(g, "sel", int'(sel), (e / 10) % 10);
              check(g, "ser_last", int'(ser_last), e % 10);
              check(g, "busy", int'(busy), 1);
              if ((e % 10) == 1) begin
                check(g, "last_cycle_ready", int'(in_ready), (GAP == 0) ? 1 : 0);
                gap_left = GAP;
              end
            end
          end else if (exp_q.size() != 0) begin
            check(g, "missing_valid", int'(ser_valid), 1);
          end
        end
      end
    end
  end

  initial begin
    bit timed_out = 1'b0;
    fork
      wait (g_inst[0].done && g_inst[1].done);
      begin
        #100000;
        timed_out = 1'b1;
      end
    join_any
    disable fork;
    if (timed_out) begin
      n_fail++;
      $display("FAIL timeout: stimulus did not complete within bound");
    end
    repeat (2) @(posedge clk);
    #1;
    check(0, "drain", g_inst[0].exp_q.size(), 0);
    check(1, "drain", g_inst[1].exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
